// File: rtl/mux_key_table.sv
// Run-time programmable key/data lookup table with a registered, handshaked response.
// On a multi-hit the lowest matching index wins and the response is flagged multi.
module mux_key_table #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 8,
  parameter int HAS_DEFAULT = 1,
  localparam int IDX_W      = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic                rsp_multi,
  output logic [15:0]         miss_cnt
);

  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [NR_KEY-1:0]   vld_q;

  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic                rsp_multi_q, rsp_multi_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  logic                wr_legal;
  logic                accept;
  logic [NR_KEY-1:0]   match;
  logic                hit_c, multi_c;
  logic [DATA_LEN-1:0] sel_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign wr_legal  = wr_en && (32'(wr_idx) < NR_KEY);
  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Stage 0: match against the pre-edge table; ascending scan keeps the lowest hit.
  always_comb begin
    hit_c    = 1'b0;
    multi_c  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = vld_q[i] && (key_q[i] == req_key);
      if (match[i]) begin
        if (hit_c) multi_c = 1'b1;
        else       sel_data = data_q[i];
        hit_c = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_multi_d = rsp_multi_q;
    miss_cnt_d  = miss_cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_hit_d   = hit_c;
      rsp_multi_d = multi_c;
      if (hit_c) begin
        rsp_data_d = sel_data;
      end else begin
        rsp_data_d = (HAS_DEFAULT != 0) ? default_out : '0;
        miss_cnt_d = sat_inc(miss_cnt_q);
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Table update: clr drops all valid bits, a legal write re-validates its entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (clr) vld_q[i] <= 1'b0;
        if (wr_legal && (wr_idx == IDX_W'(i))) begin
          key_q[i]  <= wr_key;
          data_q[i] <= wr_data;
          vld_q[i]  <= 1'b1;
        end
      end
    end
  end

  // Stage 1: response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_multi_q <= 1'b0;
      miss_cnt_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_multi_q <= rsp_multi_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_multi = rsp_multi_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_mux_key_table.sv
// Directed bench for mux_key_table built with NR_KEY = 5 so an out-of-range index exists.
module tb_mux_key_table;
  localparam int NR_KEY = 5;
  localparam int IDX_W  = $clog2(NR_KEY);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [3:0]        wr_key;
  logic [7:0]        wr_data;
  logic              clr;
  logic [7:0]        default_out;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic              rsp_hit;
  logic              rsp_multi;
  logic [15:0]       miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_key_table #(.NR_KEY(NR_KEY), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .default_out(default_out), .req_valid(req_valid),
    .req_ready(req_ready), .req_key(req_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_multi(rsp_multi), .miss_cnt(miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int idx, input logic [3:0] k, input logic [7:0] d);
    wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_key = k; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] k);
    req_valid = 1'b1; req_key = k;
    step();
    req_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [7:0] d,
                           input logic h, input logic m);
    check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    check({tag, "_data"},  32'(rsp_data),  32'(d));
    check({tag, "_hit"},   32'(rsp_hit),   32'(h));
    check({tag, "_multi"}, 32'(rsp_multi), 32'(m));
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0; clr = 1'b0;
    default_out = 8'hAA; req_valid = 1'b0; req_key = '0; rsp_ready = 1'b1;
    #3;
    check_rsp("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_miss_cnt", 32'(miss_cnt), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    #9 rst_n = 1'b1;
    step();

    // Miss on empty table returns the default.
    lookup(4'h3);
    check_rsp("empty_miss", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("empty_miss_cnt", 32'(miss_cnt), 32'd1);

    // Multi-hit: lowest index wins.
    write(0, 4'h3, 8'h11);
    write(2, 4'h3, 8'h22);
    lookup(4'h3);
    check_rsp("multi_hit", 1'b1, 8'h11, 1'b1, 1'b1);
    check("multi_hit_cnt", 32'(miss_cnt), 32'd1);

    // clr with a same-cycle write leaves only the written entry valid.
    clr = 1'b1;
    write(2, 4'h3, 8'h22);
    clr = 1'b0;
    lookup(4'h3);
    check_rsp("clr_wr", 1'b1, 8'h22, 1'b1, 1'b0);

    // Same-cycle write is invisible to the concurrent lookup.
    wr_en = 1'b1; wr_idx = 3'd1; wr_key = 4'h5; wr_data = 8'h55;
    req_valid = 1'b1; req_key = 4'h5;
    step();
    wr_en = 1'b0; req_valid = 1'b0;
    check_rsp("same_cyc", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("same_cyc_cnt", 32'(miss_cnt), 32'd2);
    lookup(4'h5);
    check_rsp("after_wr", 1'b1, 8'h55, 1'b1, 1'b0);

    // Backpressure: drain, then two lookups with rsp_ready low.
    step();
    check("drain_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_key = 4'h3;
    step();
    req_key = 4'h5;
    for (int i = 0; i < 3; i++) begin
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check_rsp("bp_hold", 1'b1, 8'h22, 1'b1, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check_rsp("bp_second", 1'b1, 8'h55, 1'b1, 1'b0);
    step();
    check("bp_no_dup", 32'(rsp_valid), 32'd0);

    // Out-of-range index must not touch the table.
    write(5, 4'h9, 8'h99);
    lookup(4'h9);
    check_rsp("oor_miss", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("oor_cnt", 32'(miss_cnt), 32'd3);
    lookup(4'h3);
    check_rsp("oor_keep", 1'b1, 8'h22, 1'b1, 1'b0);

    // Saturating miss counter; clr must not reset it.
    req_valid = 1'b1; req_key = 4'hF;
    repeat (65540) @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("sat_cnt", 32'(miss_cnt), 32'hFFFF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("sat_after_clr", 32'(miss_cnt), 32'hFFFF);
    check("sat_drain_valid", 32'(rsp_valid), 32'd0);

    // Asynchronous reset while a response is stalled.
    write(4, 4'h7, 8'h77);
    rsp_ready = 1'b0;
    lookup(4'h7);
    check_rsp("pre_rst", 1'b1, 8'h77, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_rsp("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    check("mid_rst_cnt", 32'(miss_cnt), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    #2 rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    lookup(4'h7);
    check_rsp("post_rst", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("post_rst_cnt", 32'(miss_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_key_table.md
# mux_key_table

Programmable, registered successor to the combinational key/data mux used throughout the datapath. Holds an NR_KEY-entry table of (key, data) pairs written at run time. Accepts lookup requests over a valid/ready handshake and returns the matching data one cycle later with hit/multi-hit status and an optional default. Used wherever decode or select tables must change at run time or be cut by a pipeline register (CSR select, peripheral address decode).

## Interface
- NR_KEY, 4, number of table entries (>= 2); IDX_W = $clog2(NR_KEY)
- KEY_LEN, 4, key width in bits
- DATA_LEN, 8, data width in bits
- HAS_DEFAULT, 1, 1: a miss returns default_out; 0: a miss returns all-zero data

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write one table entry this cycle
- wr_idx  in  IDX_W  entry index to write; values >= NR_KEY are ignored (no write)
- wr_key  in  KEY_LEN  key written to entry wr_idx
- wr_data  in  DATA_LEN  data written to entry wr_idx
- clr  in  1  invalidate all entries
- default_out  in  DATA_LEN  miss value, sampled when the request is accepted
- req_valid  in  1  lookup request present
- req_ready  out  1  block can accept a request this cycle
- req_key  in  KEY_LEN  key to look up
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  DATA_LEN  looked-up data
- rsp_hit  out  1  at least one valid entry matched
- rsp_multi  out  1  more than one valid entry matched
- miss_cnt  out  16  saturating count of accepted lookups that missed

## Operation
- Table: per entry, key, data and a valid bit. An entry matches only if its valid bit is set and its key equals req_key.
- Write: when wr_en and wr_idx < NR_KEY, the entry takes wr_key/wr_data and its valid bit is set at the clock edge.
- clr: clears every valid bit. Key and data contents are left unchanged. If clr and a legal wr_en occur in the same cycle, the written entry ends valid and all others end invalid.
- Lookup accept: req_valid && req_ready. The result is computed from table state before that edge's write or clr. A same-cycle write to the matching entry is not visible to that lookup.
- Priority: on a multi-hit, the lowest matching index supplies rsp_data and rsp_multi = 1. This differs from the OR-combine of the combinational mux and is intentional.
- Miss: rsp_hit = 0 and rsp_multi = 0. rsp_data = default_out when HAS_DEFAULT = 1, else 0.
- miss_cnt: increments by 1 on each accepted lookup that misses and saturates at 16'hFFFF. It is cleared only by reset; clr has no effect on it.
- Response register: rsp_data/rsp_hit/rsp_multi load only on accept and hold stable while rsp_valid && !rsp_ready.

## Timing
- Reset, asynchronous on rst_n = 0: all valid bits 0, all keys/data 0, rsp_valid 0, rsp_data 0, rsp_hit 0, rsp_multi 0, miss_cnt 0. req_ready is 1 one combinational path after reset, because rsp_valid = 0.
- Reset mid-transaction: any pending response is dropped with no output glitch beyond the asynchronous clear. Table contents are lost.
- req_ready = !rsp_valid || rsp_ready, combinational from rsp_ready. This allows full throughput of 1 lookup/cycle.
- Latency: a request accepted at edge N has its response visible after edge N with rsp_valid = 1.
- rsp_valid next state: 1 if a request is accepted; else 0 if rsp_ready; else it holds.
- Write-to-lookup: a write at edge N is visible to requests accepted at edge N+1 or later.
- No combinational path from req_key/req_valid to rsp_* outputs. The only combinational path from inputs to outputs is rsp_ready -> req_ready.

## Test plan
- Reset, then lookup key 4'h3 with default_out = 8'hAA, HAS_DEFAULT = 1 -> next cycle rsp_valid = 1, rsp_data = 8'hAA, rsp_hit = 0, miss_cnt = 1.
- Write entry 0 = (4'h3, 8'h11) and entry 2 = (4'h3, 8'h22), then look up 4'h3 -> rsp_data = 8'h11, rsp_hit = 1, rsp_multi = 1. Then clr plus write entry 2 in the same cycle, look up 4'h3 -> rsp_data = 8'h22, rsp_multi = 0.
- Same-cycle write of (4'h5, 8'h55) to entry 1 and a lookup of 4'h5 -> miss. The following lookup of 4'h5 -> hit, 8'h55.
- Back-to-back lookups with rsp_ready held 0 for 3 cycles -> req_ready = 0, rsp_* hold the first result. Release rsp_ready -> second result appears next cycle, with no loss or duplication.
- wr_idx = NR_KEY (out of range, NR_KEY = 5 build) -> table unchanged. Force 65 540 misses -> miss_cnt stays at 16'hFFFF.
- Assert rst_n low while rsp_valid = 1 and rsp_ready = 0 -> rsp_valid drops immediately. After release, a lookup of a previously written key misses.
